// File: rtl/iqft.sv
// Inverse 4-point DFT (inverse QFT): two radix-2 butterfly stages, scale by 1/4, saturate to OUT_W.
// Optional macro IQFT_ROUND_EN: round half up (+2 before >>2) instead of truncating toward -inf.
module iqft #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_r0,
    input  logic [IN_W-1:0]  in_r1,
    input  logic [IN_W-1:0]  in_r2,
    input  logic [IN_W-1:0]  in_r3,
    input  logic [IN_W-1:0]  in_i0,
    input  logic [IN_W-1:0]  in_i1,
    input  logic [IN_W-1:0]  in_i2,
    input  logic [IN_W-1:0]  in_i3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_r0,
    output logic [OUT_W-1:0] out_r1,
    output logic [OUT_W-1:0] out_r2,
    output logic [OUT_W-1:0] out_r3,
    output logic [OUT_W-1:0] out_i0,
    output logic [OUT_W-1:0] out_i1,
    output logic [OUT_W-1:0] out_i2,
    output logic [OUT_W-1:0] out_i3,
    output logic             out_sat
);

    localparam int S1_W = IN_W + 1;
    // One bit above the stage-2 width leaves room for the rounding constant.
    localparam int SW   = IN_W + 3;
    localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, ST1, ST2, OUT} state_t;

    state_t state, state_nx;

    logic signed [IN_W-1:0]  x_r [4];
    logic signed [IN_W-1:0]  x_i [4];
    logic signed [S1_W-1:0]  a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
    logic signed [SW-1:0]    y_r [4];
    logic signed [SW-1:0]    y_i [4];
    logic        [OUT_W:0]   res_r [4];
    logic        [OUT_W:0]   res_i [4];
    logic                    sat_nx;
    logic        [OUT_W-1:0] q_r [4];
    logic        [OUT_W-1:0] q_i [4];
    logic                    q_sat;

    function automatic logic signed [SW-1:0] ext(input logic signed [S1_W-1:0] v);
        return SW'(v);
    endfunction

    // Returns {saturated, value}.
    function automatic logic [OUT_W:0] scale_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
`ifdef IQFT_ROUND_EN
        t = (v + SW'(2)) >>> 2;
`else
        t = v >>> 2;
`endif
        if (t > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
        else if (t < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
        else                return {1'b0, t[OUT_W-1:0]};
    endfunction

    // NOTE: always_ff uses only non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = ST1;
            ST1:     state_nx = ST2;
            ST2:     state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_comb begin
        y_r[0] = ext(a_r) + ext(c_r);
        y_i[0] = ext(a_i) + ext(c_i);
        y_r[1] = ext(b_r) - ext(d_i);
        y_i[1] = ext(b_i) + ext(d_r);
        y_r[2] = ext(a_r) - ext(c_r);
        y_i[2] = ext(a_i) - ext(c_i);
        y_r[3] = ext(b_r) + ext(d_i);
        y_i[3] = ext(b_i) - ext(d_r);
        sat_nx = 1'b0;
        for (int k = 0; k < 4; k++) begin
            res_r[k] = scale_sat(y_r[k]);
            res_i[k] = scale_sat(y_i[k]);
            sat_nx   = sat_nx | res_r[k][OUT_W] | res_i[k][OUT_W];
        end
    end

    // NOTE: the small data arrays are reset as well, so outputs read zero after any reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                x_r[k] <= '0;
                x_i[k] <= '0;
                q_r[k] <= '0;
                q_i[k] <= '0;
            end
            {a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i} <= '0;
            q_sat <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_r[0] <= in_r0;  x_r[1] <= in_r1;  x_r[2] <= in_r2;  x_r[3] <= in_r3;
                    x_i[0] <= in_i0;  x_i[1] <= in_i1;  x_i[2] <= in_i2;  x_i[3] <= in_i3;
                end
                ST1: begin
                    a_r <= S1_W'(x_r[0]) + S1_W'(x_r[2]);
                    a_i <= S1_W'(x_i[0]) + S1_W'(x_i[2]);
                    b_r <= S1_W'(x_r[0]) - S1_W'(x_r[2]);
                    b_i <= S1_W'(x_i[0]) - S1_W'(x_i[2]);
                    c_r <= S1_W'(x_r[1]) + S1_W'(x_r[3]);
                    c_i <= S1_W'(x_i[1]) + S1_W'(x_i[3]);
                    d_r <= S1_W'(x_r[1]) - S1_W'(x_r[3]);
                    d_i <= S1_W'(x_i[1]) - S1_W'(x_i[3]);
                end
                ST2: begin
                    for (int k = 0; k < 4; k++) begin
                        q_r[k] <= res_r[k][OUT_W-1:0];
                        q_i[k] <= res_i[k][OUT_W-1:0];
                    end
                    q_sat <= sat_nx;
                end
                default: ;
            endcase
        end
    end

    assign out_r0  = q_r[0];
    assign out_r1  = q_r[1];
    assign out_r2  = q_r[2];
    assign out_r3  = q_r[3];
    assign out_i0  = q_i[0];
    assign out_i1  = q_i[1];
    assign out_i2  = q_i[2];
    assign out_i3  = q_i[3];
    assign out_sat = q_sat;

endmodule

// File: tb/tb_iqft.sv
// Self-checking bench for iqft: directed vector table, backpressure, mid-transform reset, back-to-back.
// Expected rounding results follow IQFT_ROUND_EN when the bench is built with it.
module tb_iqft;

    localparam int IN_W  = 13;
    localparam int OUT_W = 8;
    localparam int PW    = 8 * OUT_W + 1;

`ifdef IQFT_ROUND_EN
    localparam int R_P2 = 1;
    localparam int R_M2 = 0;
`else
    localparam int R_P2 = 0;
    localparam int R_M2 = -1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_sat;
    logic [IN_W-1:0]  in_r0 = '0, in_r1 = '0, in_r2 = '0, in_r3 = '0;
    logic [IN_W-1:0]  in_i0 = '0, in_i1 = '0, in_i2 = '0, in_i3 = '0;
    logic [OUT_W-1:0] out_r0, out_r1, out_r2, out_r3, out_i0, out_i1, out_i2, out_i3;

    always #5 clk = ~clk;

    iqft #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r0(in_r0), .in_r1(in_r1), .in_r2(in_r2), .in_r3(in_r3),
        .in_i0(in_i0), .in_i1(in_i1), .in_i2(in_i2), .in_i3(in_i3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r0(out_r0), .out_r1(out_r1), .out_r2(out_r2), .out_r3(out_r3),
        .out_i0(out_i0), .out_i1(out_i1), .out_i2(out_i2), .out_i3(out_i3),
        .out_sat(out_sat)
    );

    typedef struct packed {
        logic [3:0][15:0] r;
        logic [3:0][15:0] i;
        logic [3:0][15:0] er;
        logic [3:0][15:0] ei;
        logic             sat;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tab [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][15:0] q4(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][15:0] q;
        q[0] = 16'(a0);  q[1] = 16'(a1);  q[2] = 16'(a2);  q[3] = 16'(a3);
        return q;
    endfunction

    function automatic logic [PW-1:0] exp_pack(input vec_t v);
        return {v.sat,
                v.er[0][OUT_W-1:0], v.er[1][OUT_W-1:0], v.er[2][OUT_W-1:0], v.er[3][OUT_W-1:0],
                v.ei[0][OUT_W-1:0], v.ei[1][OUT_W-1:0], v.ei[2][OUT_W-1:0], v.ei[3][OUT_W-1:0]};
    endfunction

    function automatic logic [PW-1:0] dut_pack();
        return {out_sat, out_r0, out_r1, out_r2, out_r3, out_i0, out_i1, out_i2, out_i3};
    endfunction

    function automatic int scale_sat(input int s, inout bit sat);
        int t;
`ifdef IQFT_ROUND_EN
        t = (s + 2) >>> 2;
`else
        t = s >>> 2;
`endif
        if (t > 127) begin t = 127; sat = 1'b1; end
        if (t < -128) begin t = -128; sat = 1'b1; end
        return t;
    endfunction

    // Direct inverse DFT: x[n] = sum_k X[k] * j^(n*k), then /4 and clamp.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        bit   sat = 1'b0;
        for (int n = 0; n < 4; n++) begin
            int sr = 0;
            int si = 0;
            for (int k = 0; k < 4; k++) begin
                int xr = $signed(v.r[k]);
                int xi = $signed(v.i[k]);
                case ((n * k) % 4)
                    0: begin sr += xr; si += xi; end
                    1: begin sr -= xi; si += xr; end
                    2: begin sr -= xr; si -= xi; end
                    default: begin sr += xi; si -= xr; end
                endcase
            end
            o.er[n] = 16'(scale_sat(sr, sat));
            o.ei[n] = 16'(scale_sat(si, sat));
        end
        o.sat = sat;
        return o;
    endfunction

    task automatic drive(input vec_t v);
        in_r0 = v.r[0][IN_W-1:0];  in_r1 = v.r[1][IN_W-1:0];
        in_r2 = v.r[2][IN_W-1:0];  in_r3 = v.r[3][IN_W-1:0];
        in_i0 = v.i[0][IN_W-1:0];  in_i1 = v.i[1][IN_W-1:0];
        in_i2 = v.i[2][IN_W-1:0];  in_i3 = v.i[3][IN_W-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    // Accept one spectrum, compare the result, then consume it.
    task automatic run_vec(input string name, input vec_t v, input bit chk_lat);
        int cyc;
        drive(v);
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check({name, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_out_valid(cyc);
        // Accept cycle counts as cycle 0; out_valid must be visible in cycle 3.
        if (chk_lat) check({name, "_latency"}, cyc + 1, 3);
        check({name, "_out_valid"}, out_valid, 1'b1);
        check({name, "_data"}, dut_pack(), exp_pack(v));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        vec_t bv [4];
        logic [PW-1:0] expq [$];
        int cyc, idx, last_t, n_out;
        bit acc;

        tab[0] = '{r: q4(20, -4, -4, -4), i: q4(0, 4, 0, -4),
                   er: q4(2, 4, 6, 8), ei: q4(0, 0, 0, 0), sat: 1'b0};
        tab[1] = '{r: q4(2, 0, 0, 0), i: q4(0, 0, 0, 0),
                   er: q4(R_P2, R_P2, R_P2, R_P2), ei: q4(0, 0, 0, 0), sat: 1'b0};
        tab[2] = '{r: q4(-2, 0, 0, 0), i: q4(0, 0, 0, 0),
                   er: q4(R_M2, R_M2, R_M2, R_M2), ei: q4(0, 0, 0, 0), sat: 1'b0};
        tab[3] = '{r: q4(4095, 4095, 4095, 4095), i: q4(0, 0, 0, 0),
                   er: q4(127, 0, 0, 0), ei: q4(0, 0, 0, 0), sat: 1'b1};
        tab[4] = '{r: q4(4, 0, 0, 0), i: q4(0, 0, 0, 0),
                   er: q4(1, 1, 1, 1), ei: q4(0, 0, 0, 0), sat: 1'b0};
        tab[5] = '{r: q4(-4096, -4096, -4096, -4096), i: q4(0, 0, 0, 0),
                   er: q4(-128, 0, 0, 0), ei: q4(0, 0, 0, 0), sat: 1'b1};
        tab[6] = '{r: q4(0, 0, 0, 0), i: q4(0, 4, 0, 0),
                   er: q4(0, -1, 0, 1), ei: q4(1, 0, -1, 0), sat: 1'b0};
        tab[7] = '{r: q4(0, 0, 0, 8), i: q4(0, 0, 0, 0),
                   er: q4(2, 0, -2, 0), ei: q4(0, -2, 0, 2), sat: 1'b0};
        tab[8] = '{r: q4(0, 0, 8, 0), i: q4(0, 0, 0, 0),
                   er: q4(2, -2, 2, -2), ei: q4(0, 0, 0, 0), sat: 1'b0};

        #12;
        check("reset_hs", {out_valid, in_ready}, 2'b01);
        check("reset_data", dut_pack(), '0);
        #11 rst_n = 1'b1;
        tick();

        for (int t = 0; t < 9; t++) run_vec($sformatf("vec%0d", t), tab[t], t == 0);

        // Backpressure: result held for 10 cycles, an in_valid pulse meanwhile is ignored.
        drive(tab[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(cyc);
        check("bp_out_valid", out_valid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                drive(tab[1]);
                in_valid = 1'b1;
            end
            if (c == 5) in_valid = 1'b0;
            tick();
            check($sformatf("bp_hold%0d", c), {out_valid, in_ready, dut_pack()},
                  {2'b10, exp_pack(tab[0])});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {out_valid, in_ready}, 2'b01);
        repeat (4) tick();
        check("bp_no_capture", {out_valid, in_ready}, 2'b01);
        run_vec("bp_next", tab[6], 1'b0);

        // Reset during ST1 discards the transform and clears the held outputs.
        drive(tab[3]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_in_st1", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid", {out_valid, in_ready, dut_pack()}, {2'b01, {PW{1'b0}}});
        #3 rst_n = 1'b1;
        repeat (4) tick();
        check("rst_no_stale", {out_valid, in_ready}, 2'b01);
        run_vec("rst_next", tab[7], 1'b1);

        // Back-to-back with in_valid and out_ready held high.
        for (int k = 0; k < 4; k++) begin
            vec_t v = '0;
            for (int e = 0; e < 4; e++) begin
                v.r[e] = (k == 3) ? 16'(4000) : 16'(int'($urandom_range(0, 1200)) - 600);
                v.i[e] = 16'(int'($urandom_range(0, 1200)) - 600);
            end
            bv[k] = model(v);
        end
        idx = 0;
        last_t = -1;
        n_out = 0;
        drive(bv[0]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        acc = in_ready && in_valid;
        for (int c = 0; c < 60 && n_out < 4; c++) begin
            tick();
            if (acc) begin
                expq.push_back(exp_pack(bv[idx]));
                idx++;
                if (idx < 4) drive(bv[idx]);
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (expq.size() == 0) check("b2b_spurious", 1'b1, 1'b0);
                else check($sformatf("b2b_data%0d", n_out), dut_pack(), expq.pop_front());
                if (last_t >= 0) check($sformatf("b2b_interval%0d", n_out), c - last_t, 4);
                last_t = c;
                n_out++;
            end
            acc = in_ready && in_valid;
        end
        check("b2b_count", n_out, 4);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iqft.md
# iqft

Inverse 4-point quantum Fourier transform (inverse DFT) engine. It takes the 4-element complex spectrum produced by the forward `qft` block and reconstructs the original 4-element complex amplitude vector, scaled by 1/4. It runs as a two-stage radix-2 butterfly with valid/ready handshakes on both sides, and sits downstream of `qft` in the round-trip path.

## Interface
- IN_W, 13 — signed width of each input real/imag component (matches `qft` output width)
- OUT_W, 8 — signed width of each output real/imag component
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  spectrum on in_* is valid
- in_ready  output  1  block can accept a spectrum
- in_r0..in_r3  input  IN_W  real parts X0..X3, two's complement
- in_i0..in_i3  input  IN_W  imaginary parts X0..X3, two's complement
- out_valid  output  1  result on out_* is valid
- out_ready  input  1  downstream accepts result
- out_r0..out_r3  output  OUT_W  real parts x0..x3
- out_i0..out_i3  output  OUT_W  imaginary parts x0..x3
- out_sat  output  1  at least one of the 8 outputs of this result was saturated

## Operation
- Math: x[n] = (1/4)·Σ X[k]·j^(nk). The sign is positive (inverse) and W^-1 = +j.
- FSM states: IDLE, ST1, ST2, OUT.
  - IDLE: in_ready=1. On in_valid, register all 8 inputs (sign-extended) and go to ST1.
  - ST1: compute stage 1 from the complex values: a=X0+X2, b=X0−X2, c=X1+X3, d=X1−X3. Register these at IN_W+1 bits, then go to ST2.
  - ST2: compute stage 2 at IN_W+2 bits:
    - x0=a+c, x2=a−c
    - x1_r=b_r−d_i, x1_i=b_i+d_r
    - x3_r=b_r+d_i, x3_i=b_i−d_r
    - Scale each value by an arithmetic right shift of 2, then saturate to OUT_W, clamping to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
    - Register the 8 outputs and out_sat, then go to OUT.
  - OUT: out_valid=1. The outputs and out_sat hold stable until out_valid && out_ready; on that edge go to IDLE.
- in_ready=0 in ST1, ST2 and OUT. in_valid in those states is ignored and the data is not captured.
- The internal sums never overflow at IN_W+2 bits. Saturation occurs only in the final OUT_W narrowing.
- Reset (any state, including mid-transform): state goes to IDLE. All out_r*/out_i* = 0, out_sat=0, out_valid=0, in_ready=1. Any in-flight transform is discarded.

## Timing
- Accept edge E0 (IDLE, in_valid=1). ST1 result is registered at E1. Outputs are registered at E2, and out_valid is high after E2.
- Latency: 3 cycles from accept to out_valid.
- With out_ready held high, the result is consumed at E3 and in_ready is high after E3. Maximum throughput is one transform per 4 cycles.
- out_ready low: out_valid and the data hold indefinitely, with no loss.
- in_valid may be held across the busy period. The same data is re-accepted only when the block has returned to IDLE.

## Configuration
- IQFT_ROUND_EN defined: the scaling step adds 2 before the >>2, which is round-half-up toward +∞.
- IQFT_ROUND_EN undefined: the scaling step is a plain arithmetic >>2, which is floor/truncation toward −∞.
- The rounding adder is sized so it cannot overflow IN_W+2 bits.

## Test plan
- Round trip: X0=20, X1=−4+4j, X2=−4, X3=−4−4j, other imaginary parts 0 → out_r={2,4,6,8} and out_i={0,0,0,0} in both configs. out_sat=0 and out_valid rises 3 cycles after accept.
- Rounding: X0=2 (all else 0) → every out_r=0 without IQFT_ROUND_EN, 1 with it. X0=−2 → every out_r=−1 without, 0 with. All out_i=0.
- Saturation: all in_r*=4095 and all in_i*=0 → out_r0=127, out_r1..3=0, all out_i=0, out_sat=1 (OUT_W=8). The next transform with small values → out_sat=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs must stay stable and in_ready must stay 0. A new in_valid pulse during this time is ignored. Raising out_ready → IDLE, and the next accepted spectrum produces a correct result.
- Reset mid-operation: drop rst_n during ST1 → immediately out_valid=0, in_ready=1, all outputs 0. After release, a new transform completes normally with no stale data.
- Back-to-back: with in_valid and out_ready held high and inputs changing on each accept, results appear every 4 cycles in order and each matches the reference model.
